serial_adder_ctrl: RTL

- Bit-serial N-bit adder controller that sequences a single 1-bit full adder over two WIDTH-bit operands, LSB first, one bit per clock.
- Start/busy/done handshake toward the requester. Registered sum/cout hold the last completed result.
- Area-minimal alternative to a ripple-carry chain, for slow arithmetic paths in the adders library.

---
 rtl/adder_pkg.sv | 10 +
 rtl/full_adder_using_half_adder.sv | 21 ++
 rtl/serial_adder_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types for the adders library
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

endpackage

// File: rtl/full_adder_using_half_adder.sv
// rtl/full_adder_using_half_adder.sv - 1-bit full adder composed of two half-add stages
module full_adder_using_half_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic hs;
    logic hc0;
    logic hc1;

    // First half-add on a/b, second folds in the carry.
    assign hs   = a ^ b;
    assign hc0  = a & b;
    assign sum  = hs ^ cin;
    assign hc1  = hs & cin;
    assign cout = hc0 | hc1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder, LSB first, start/busy/done handshake
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    adder_state_t   state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    full_adder_using_half_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .sum  (s_bit),
        .cout (c_bit)
    );

    // The sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at sr[0].
    generate
        if (WIDTH == 1) begin : g_sr1
            assign sr_next = s_bit;
        end else begin : g_srn
            assign sr_next = {s_bit, sr[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state == RUN) || (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sr  <= sr_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= c_bit;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= sr_next;
                        cout  <= c_bit;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
